bus_slave_packer: RTL and testbench
===================================

BUS_SLAVE_PACKER -- requirements
Module: bus_slave_packer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, word FIFO depth in 32-bit words (power of two, >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: bus  interface  bus_if.slave  byte stream in (data 8 in, valid 1 in, ready 1 out).
REQ-005 SHALL have port: flush  input  1  discard partially assembled word.
REQ-006 SHALL have port: word_data  output  32  head-of-FIFO word.
REQ-007 SHALL have port: word_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port: word_ready  input  1  downstream accepts word.
REQ-009 SHALL have port: level  output  $clog2(DEPTH+1)  FIFO occupancy in words.
REQ-010 SHALL have port: beat_cnt  output  2  bytes held in the partial word.

Function
REQ-011 SHALL treat a byte as accepted when bus.valid && bus.ready at a rising edge.
REQ-012 SHALL drive bus.ready = !(level == DEPTH), combinational from registered state only; no path from word_ready to bus.ready.
REQ-013 SHALL pack little-endian: byte k of a word (k = beat_cnt at acceptance) lands in word bits [8k+7:8k].
REQ-014 SHALL increment beat_cnt on each accepted byte, wrapping 3 -> 0; the byte accepted at beat_cnt == 3 completes the word and pushes it into the FIFO on the same edge.
REQ-015 SHALL give latency: 4th byte accepted at edge N with FIFO empty -> word_valid = 1 and word_data valid immediately after edge N.
REQ-016 SHALL pop the FIFO when word_valid && word_ready; word_data = oldest word (first-word fall-through).
REQ-017 SHALL keep level unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-018 SHALL wrap read and write pointers modulo DEPTH without gaps or duplicates.
REQ-019 SHALL hold bus.ready low while full, including the cycle a pop occurs; ready rises the cycle after the pop.
REQ-020 SHALL hold word_data stable while word_valid && !word_ready.
REQ-021 SHALL, on flush, set beat_cnt to 0 and discard partial bytes; FIFO contents and level unaffected.
REQ-022 SHALL, on flush coincident with an accepted byte, give flush priority: the byte is consumed (ready unchanged) and dropped; no push occurs even when beat_cnt == 3.
REQ-023 SHALL ignore bus.data when bus.valid is low; X on data with valid low has no effect.

Reset
REQ-024 SHALL, on rst = 1 at a rising edge, set beat_cnt = 0, level = 0, pointers = 0, word_valid = 0, bus.ready = 1 from the following cycle.
REQ-025 SHALL give rst priority over flush, push and pop; reset mid-word or with a non-empty FIFO discards all data.
REQ-026 SHALL not require word_data storage to be reset; word_data is don't-care while word_valid = 0.

Structure
REQ-027 SHALL take BEAT_W = 8, WORD_W = 32, BEATS_PER_WORD = 4 and typedef word_t (logic [31:0]) from shared package bus_pkg.
REQ-028 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level, synchronous active-high reset); packing logic stays in bus_slave_packer.

Verification
REQ-029 SHALL cover basic packing: bytes 0x11,0x22,0x33,0x44 back-to-back with word_ready = 1 -> word_data = 0x44332211, word_valid high one cycle after the 4th byte, level returns to 0.
REQ-030 SHALL cover full backpressure: DEPTH = 4, word_ready = 0, 20 bytes offered -> 16 accepted, level = 4, bus.ready = 0; raise word_ready one cycle -> one pop, bus.ready = 1 next cycle, words emerge in order.
REQ-031 SHALL cover simultaneous push/pop: level = 2, 4th byte accepted while popping -> level stays 2, order preserved.
REQ-032 SHALL cover flush: 0xAA,0xBB accepted, flush, then 0x01..0x04 -> single word 0x04030201; flush with 4th byte -> no word pushed, beat_cnt = 0.
REQ-033 SHALL cover reset mid-operation: level = 3, beat_cnt = 2, rst for 1 cycle -> level = 0, beat_cnt = 0, word_valid = 0, bus.ready = 1 next cycle.
REQ-034 SHALL cover pointer wrap: 3*DEPTH+1 words streamed with random valid/word_ready gaps -> scoreboard matches every word, no loss or duplication.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus geometry for the byte-to-word packing path.
package bus_pkg;
  localparam int BEAT_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BEATS_PER_WORD = 4;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/bus_if.sv
// Byte-stream valid/ready channel.
interface bus_if;
  import bus_pkg::*;
  beat_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; storage is left unreset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/bus_slave_packer.sv
// Packs a little-endian byte stream into 32-bit words queued in a small FIFO.
module bus_slave_packer
  import bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  bus_if.slave                       bus,
  input  logic                       flush,
  output word_t                      word_data,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [1:0]                 beat_cnt
);
  localparam int PART_W = WORD_W - BEAT_W;

  logic [1:0]        beat_q, beat_d;
  logic [PART_W-1:0] part_q, part_d;
  logic              full, empty, accept, push, pop;
  word_t             push_word;

  // Ready depends only on registered occupancy, so a pop never opens it same-cycle.
  assign bus.ready  = !full;
  assign accept     = bus.valid && bus.ready;
  assign push       = accept && !flush && (beat_q == 2'd3);
  assign push_word  = {bus.data, part_q};
  assign word_valid = !empty;
  assign pop        = word_valid && word_ready;
  assign beat_cnt   = beat_q;

  always_comb begin
    beat_d = beat_q;
    part_d = part_q;
    if (flush) begin
      beat_d = 2'd0;
    end else if (accept) begin
      beat_d = beat_q + 2'd1;
      case (beat_q)
        2'd0:    part_d[7:0]   = bus.data;
        2'd1:    part_d[15:8]  = bus.data;
        2'd2:    part_d[23:16] = bus.data;
        default: part_d        = part_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) beat_q <= 2'd0;
    else     beat_q <= beat_d;
  end

  // Stale partial bytes are harmless: each lane is rewritten before reuse.
  always_ff @(posedge clk) begin
    part_q <= part_d;
  end

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (word_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_bus_slave_packer.sv
// Directed and randomized-gap bench with a queue-based reference model.
module tb_bus_slave_packer;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, flush, word_ready;
  logic [31:0]   word_data;
  logic          word_valid;
  logic [LW-1:0] level;
  logic [1:0]    beat_cnt;

  bus_if bus_i();

  bus_slave_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus_i.slave), .flush(flush),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .level(level), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue plus list of pending bytes.
  logic [31:0] mq[$];
  logic [7:0]  mp[$];
  bit          started = 0;
  int          accs = 0, pops = 0;

  always @(posedge clk) begin
    bit m_acc, m_pop;
    if (rst) begin
      mq.delete(); mp.delete(); started = 1;
    end else if (started) begin
      m_acc = bus_i.valid && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && word_ready;
      if (m_pop) begin void'(mq.pop_front()); pops++; end
      if (flush) mp.delete();
      else if (m_acc) begin
        mp.push_back(bus_i.data);
        accs++;
        if (mp.size() == 4) begin
          mq.push_back({mp[3], mp[2], mp[1], mp[0]});
          mp.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", 32'(bus_i.ready), 32'(mq.size() < DEPTH));
      chk("word_valid", 32'(word_valid), 32'(mq.size() > 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("beat_cnt", 32'(beat_cnt), 32'(mp.size()));
      if (mq.size() > 0) chk("word_data", word_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus_i.valid = 1'b1; bus_i.data = d; step();
    bus_i.valid = 1'b0; bus_i.data = 'x;
  endtask

  task automatic drain();
    int n = 0;
    bus_i.valid = 1'b0; word_ready = 1'b1;
    while (mq.size() > 0 && n < 50) begin step(); n++; end
    chk("drain_timeout", 32'(mq.size()), 32'd0);
    word_ready = 1'b0;
  endtask

  initial begin
    int n, a0, p0;
    rst = 1'b1; flush = 1'b0; word_ready = 1'b0;
    bus_i.valid = 1'b0; bus_i.data = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus_i.ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);

    // basic packing
    word_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk("basic_no_valid_yet", 32'(word_valid), 32'd0);
    send(8'h44);
    chk("basic_valid", 32'(word_valid), 32'd1);
    chk("basic_data", word_data, 32'h44332211);
    step();
    chk("basic_level0", 32'(level), 32'd0);

    // full backpressure
    word_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_i.valid = 1'b1; bus_i.data = 8'(i + 1); step();
    end
    bus_i.valid = 1'b0;
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_ready", 32'(bus_i.ready), 32'd0);
    chk("bp_head", word_data, 32'h04030201);
    chk("bp_beat", 32'(beat_cnt), 32'd0);
    word_ready = 1'b1;
    chk("bp_ready_during_pop", 32'(bus_i.ready), 32'd0);
    step();
    word_ready = 1'b0;
    chk("bp_level_after_pop", 32'(level), 32'd3);
    chk("bp_ready_after_pop", 32'(bus_i.ready), 32'd1);
    chk("bp_head2", word_data, 32'h08070605);
    drain();

    // simultaneous push and pop
    for (int i = 0; i < 11; i++) send(8'hA0 + 8'(i));
    chk("sim_level_pre", 32'(level), 32'd2);
    word_ready = 1'b1;
    send(8'hAB);
    word_ready = 1'b0;
    chk("sim_level", 32'(level), 32'd2);
    chk("sim_head", word_data, 32'hA7A6A5A4);
    drain();

    // flush
    send(8'hAA); send(8'hBB);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_beat", 32'(beat_cnt), 32'd0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("flush_level", 32'(level), 32'd1);
    chk("flush_word", word_data, 32'h04030201);
    drain();
    send(8'h10); send(8'h20); send(8'h30);
    flush = 1'b1; send(8'h40); flush = 1'b0;
    chk("flush4_level", 32'(level), 32'd0);
    chk("flush4_beat", 32'(beat_cnt), 32'd0);
    chk("flush4_valid", 32'(word_valid), 32'd0);

    // reset mid-operation
    for (int i = 0; i < 14; i++) send(8'hC0 + 8'(i));
    chk("mid_level", 32'(level), 32'd3);
    chk("mid_beat", 32'(beat_cnt), 32'd2);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_beat", 32'(beat_cnt), 32'd0);
    chk("mid_rst_valid", 32'(word_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus_i.ready), 32'd1);

    // pointer wrap with random gaps
    a0 = accs; p0 = pops; n = 0;
    while ((accs - a0) < 4 * (3 * DEPTH + 1) && n < 3000) begin
      bus_i.valid = 1'($urandom_range(0, 1));
      bus_i.data  = bus_i.valid ? 8'($urandom) : 'x;
      word_ready  = 1'($urandom_range(0, 1));
      step(); n++;
    end
    chk("rand_timeout", 32'(accs - a0), 32'(4 * (3 * DEPTH + 1)));
    drain();
    chk("rand_words", 32'(pops - p0), 32'(3 * DEPTH + 1));

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
